// File: rtl/buffer_512_to_64_fifo_pkg.sv
// buffer_pkg: shared widths and types for the 512-to-64 width-converting FIFO.
//   CL_BITS      - cache line width written by the host read path
//   WORD_BITS    - word width delivered to the compute kernel
//   WORDS_PER_CL - words per line
//   cl_word()    - extract word idx from a line, word 0 = bits [63:0]
package buffer_pkg;

    localparam int CL_BITS      = 512;
    localparam int WORD_BITS    = 64;
    localparam int WORDS_PER_CL = CL_BITS / WORD_BITS;

    typedef logic [CL_BITS-1:0]   t_cl;
    typedef logic [WORD_BITS-1:0] t_word;

    function automatic t_word cl_word(input t_cl line, input logic [2:0] idx);
        return line[idx*WORD_BITS +: WORD_BITS];
    endfunction

endpackage

// File: rtl/buffer_512_to_64_fifo_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port.
//   clk       - clock
//   i_wr_en   - write i_wr_data at i_wr_addr
//   i_wr_addr - write address
//   i_wr_data - write data
//   i_rd_en   - capture mem[i_rd_addr] into o_rd_data; o_rd_data holds otherwise
//   i_rd_addr - read address
//   o_rd_data - registered read data
// No reset on the array or the read register so it maps onto block RAM.
module sdp_ram #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en)
            o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/buffer_512_to_64_fifo.sv
// buffer_512_to_64_fifo: accepts 512-bit lines, delivers them as eight 64-bit
// words (word 0 = data_in[63:0] first), with an early almost-full level.
//   clk       - clock
//   reset     - synchronous active-high reset, clears all state
//   clr       - synchronous active-high flush, same effect as reset
//   data_in   - line to write
//   wr_enable - push data_in (dropped when full)
//   data_out  - word popped by the previous accepted read, held otherwise
//   rd_enable - pop one word (ignored when empty)
//   full      - all DEPTH_LINES slots occupied
//   empty     - no unread words remain
//   full_n    - almost full: occupied lines >= DEPTH_LINES - AFULL_MARGIN
module buffer_512_to_64_fifo
    import buffer_pkg::*;
#(
    parameter int DEPTH_LINES  = 128,
    parameter int AFULL_MARGIN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic [CL_BITS-1:0]   data_in,
    input  logic                 wr_enable,
    output logic [WORD_BITS-1:0] data_out,
    input  logic                 rd_enable,
    output logic                 full,
    output logic                 empty,
    output logic                 full_n
);

    localparam int AW = $clog2(DEPTH_LINES);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH_LINES);
    localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH_LINES - AFULL_MARGIN);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [2:0]    r_word_idx;
    logic [CW-1:0] r_count;
    logic [2:0]    r_out_sel;
    logic          r_out_vld;

    logic          w_flush;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_line_done;
    t_cl           w_rd_line;

    assign w_flush     = reset | clr;
    // Acceptance uses flags from the pre-edge count only: a freeing read
    // does not open a slot for the same cycle's write, and there is no
    // write-to-read bypass.
    assign w_wr_acc    = wr_enable & ~full & ~w_flush;
    assign w_rd_acc    = rd_enable & ~empty & ~w_flush;
    assign w_line_done = w_rd_acc & (r_word_idx == 3'd7);

    assign empty  = (r_count == '0);
    assign full   = (r_count == FULL_LVL);
    assign full_n = (r_count >= AFULL_LVL);

    // Write and read slots never collide: when not full and not empty the
    // write pointer differs from the read pointer.
    sdp_ram #(
        .WIDTH (CL_BITS),
        .DEPTH (DEPTH_LINES),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_line)
    );

    // The RAM's read register plus the registered word select form the
    // output register, giving one-cycle read latency. Both only update on an
    // accepted read, so data_out holds between reads. r_out_vld forces zero
    // after reset/flush since the RAM register itself is not reset.
    assign data_out = r_out_vld ? cl_word(w_rd_line, r_out_sel) : '0;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_word_idx <= '0;
            r_count    <= '0;
            r_out_sel  <= '0;
            r_out_vld  <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            if (w_rd_acc) begin
                r_word_idx <= r_word_idx + 3'd1;
                r_out_sel  <= r_word_idx;
                r_out_vld  <= 1'b1;
            end
            if (w_line_done)
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            r_count <= r_count + {{(CW-1){1'b0}}, w_wr_acc}
                               - {{(CW-1){1'b0}}, w_line_done};
        end
    end

endmodule

// File: tb/tb_buffer_512_to_64_fifo.sv
module tb_buffer_512_to_64_fifo;
    import buffer_pkg::*;

    localparam int DEPTH  = 128;
    localparam int MARGIN = 32;

    logic  clk = 1'b0;
    logic  reset, clr, wr_enable, rd_enable;
    t_cl   data_in;
    t_word data_out;
    logic  full, empty, full_n;

    int checks = 0;
    int errors = 0;

    buffer_512_to_64_fifo #(.DEPTH_LINES(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
        .clk(clk), .reset(reset), .clr(clr), .data_in(data_in),
        .wr_enable(wr_enable), .data_out(data_out), .rd_enable(rd_enable),
        .full(full), .empty(empty), .full_n(full_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a flat queue of words in delivery order; occupied lines are the
    // words remaining rounded up to whole lines.
    t_word mq[$];
    t_word m_out = '0;
    bit    chk_en = 0;

    function automatic int m_lines();
        return (mq.size() + 7) / 8;
    endfunction

    always @(posedge clk) begin
        if (reset || clr) begin
            mq.delete();
            m_out = '0;
        end else begin
            bit e_pre, f_pre;
            e_pre = (mq.size() == 0);
            f_pre = (m_lines() == DEPTH);
            if (rd_enable && !e_pre) m_out = mq.pop_front();
            if (wr_enable && !f_pre)
                for (int k = 0; k < 8; k++) mq.push_back(data_in[k*64 +: 64]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out", data_out, m_out);
            chk("empty",    64'(empty),  64'(mq.size() == 0));
            chk("full",     64'(full),   64'(m_lines() == DEPTH));
            chk("full_n",   64'(full_n), 64'(m_lines() >= DEPTH - MARGIN));
        end
    end

    function automatic t_cl mkline(input int n);
        t_cl l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = {32'(n), 32'(k)};
        return l;
    endfunction

    task automatic cyc(input bit w, input bit r, input t_cl d);
        @(negedge clk);
        wr_enable = w;
        rd_enable = r;
        data_in   = d;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        t_cl l0;
        reset = 1'b1; clr = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1;
        settle();
        chk("rst_empty",    64'(empty),  64'd1);
        chk("rst_full",     64'(full),   64'd0);
        chk("rst_full_n",   64'(full_n), 64'd0);
        chk("rst_data_out", data_out,    64'd0);

        // Single line {7,6,...,0}, eight reads give 0..7.
        for (int k = 0; k < 8; k++) l0[k*64 +: 64] = 64'(k);
        cyc(1, 0, l0);
        settle();
        chk("wr_not_empty", 64'(empty), 64'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, '0);
            settle();
            chk("line0_word", data_out, 64'(i));
        end
        chk("line0_empty", 64'(empty), 64'd1);

        // Read while empty holds data_out.
        cyc(0, 1, '0);
        settle();
        chk("empty_rd_hold", data_out, 64'd7);
        chk("empty_rd_flag", 64'(empty), 64'd1);
        cyc(1, 0, mkline(42));
        cyc(0, 1, '0);
        settle();
        chk("after_empty_w0", data_out, {32'd42, 32'd0});
        repeat (7) cyc(0, 1, '0);

        // Fill to full, watching almost-full and full thresholds.
        for (int i = 0; i < 128; i++) begin
            cyc(1, 0, mkline(i));
            settle();
            if (i == 94)  chk("full_n_95", 64'(full_n), 64'd0);
            if (i == 95)  chk("full_n_96", 64'(full_n), 64'd1);
            if (i == 126) chk("full_127",  64'(full),   64'd0);
            if (i == 127) chk("full_128",  64'(full),   64'd1);
        end
        cyc(1, 0, mkline(999));  // dropped
        repeat (7) cyc(0, 1, '0);
        settle();
        chk("drain_w6", data_out, {32'd0, 32'd6});
        // Word 7 read frees a line; the write in the same cycle is refused.
        cyc(1, 1, mkline(555));
        settle();
        chk("rw_full_w7",   data_out,    {32'd0, 32'd7});
        chk("rw_full_fall", 64'(full),   64'd0);
        chk("rw_full_n",    64'(full_n), 64'd1);
        cyc(0, 1, '0);
        settle();
        chk("line1_w0", data_out, {32'd1, 32'd0});
        repeat (127*8 - 1) cyc(0, 1, '0);
        settle();
        chk("last_word",   data_out,   {32'd127, 32'd7});
        chk("drain_empty", 64'(empty), 64'd1);

        // Sustained traffic: one line per 8 cycles, one read per cycle.
        for (int c = 0; c < 1000; c++) cyc(c % 8 == 0, 1, mkline(1000 + c));
        repeat (16) cyc(0, 1, '0);
        cyc(0, 0, '0);
        settle();
        chk("stream_empty", 64'(empty), 64'd1);

        // Flush with traffic present.
        for (int i = 0; i < 4; i++) cyc(1, 0, mkline(2000 + i));
        repeat (10) cyc(0, 1, '0);
        @(negedge clk);
        clr = 1'b1; wr_enable = 1'b1; rd_enable = 1'b1; data_in = mkline(7777);
        settle();
        chk("clr_empty",    64'(empty),  64'd1);
        chk("clr_full_n",   64'(full_n), 64'd0);
        chk("clr_data_out", data_out,    64'd0);
        @(negedge clk);
        clr = 1'b0; wr_enable = 1'b1; rd_enable = 1'b0; data_in = mkline(3000);
        cyc(0, 1, '0);
        settle();
        chk("post_clr_w0", data_out, {32'd3000, 32'd0});
        repeat (7) cyc(0, 1, '0);
        cyc(0, 0, '0);
        settle();
        chk("post_clr_last", data_out, {32'd3000, 32'd7});

        @(negedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
